// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction-fetch stage control between F and D registers
//
// Runs one request/response transaction per PC on the instruction bus and
// presents the fetch payload (pc, instr, valid, address error) to the D
// register. Requests a PC hold while the instruction is not yet available and
// squashes in-flight fetches on redirect.
//
// Optional feature macro: IFETCH_ADEL_EN (misaligned-PC address-error detection).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc                  current fetch PC from the F register
//   stall_d             D register not accepting this cycle
//   flush               redirect: squash the current fetch
//   inst_req/inst_addr  bus request valid / address
//   inst_addr_ok        request accepted this cycle
//   inst_data_ok        read data valid this cycle
//   inst_rdata          read data
//   f_valid/f_pc/f_instr/f_adel  payload for the D register
//   stall_f_req         hold PC: instruction for pc not yet delivered
module ifetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall_d,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_adel,
  output logic        stall_f_req
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      state, state_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic        req, valid;
  logic [31:0] instr;
`ifdef IFETCH_ADEL_EN
  logic        hold_adel, hold_adel_nx;
  logic        adel;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      hold_buf <= 32'h0;
`ifdef IFETCH_ADEL_EN
      hold_adel <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      hold_buf <= hold_buf_nx;
`ifdef IFETCH_ADEL_EN
      hold_adel <= hold_adel_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    hold_buf_nx = hold_buf;
    req         = 1'b0;
    valid       = 1'b0;
    instr       = 32'h0;
`ifdef IFETCH_ADEL_EN
    hold_adel_nx = hold_adel;
    adel         = 1'b0;
`endif
    case (state)
      S_REQ: begin
        // Flush withdraws the request; late data_ok here is never looked at.
        if (!flush) begin
`ifdef IFETCH_ADEL_EN
          // Misaligned PC: deliver an error payload without touching the bus.
          if (pc[1:0] != 2'b00) begin
            valid = 1'b1;
            adel  = 1'b1;
            if (stall_d) begin
              state_nx     = S_HOLD;
              hold_buf_nx  = 32'h0;
              hold_adel_nx = 1'b1;
            end
          end else
`endif
          begin
            req = 1'b1;
            if (inst_addr_ok) state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          // Data arriving with the flush closes the transaction outright.
          state_nx = inst_data_ok ? S_REQ : S_DISCARD;
        end else if (inst_data_ok) begin
          valid = 1'b1;
          instr = inst_rdata;
          if (stall_d) begin
            state_nx    = S_HOLD;
            hold_buf_nx = inst_rdata;
`ifdef IFETCH_ADEL_EN
            hold_adel_nx = 1'b0;
`endif
          end else begin
            state_nx = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_nx    = S_REQ;
          hold_buf_nx = 32'h0;
`ifdef IFETCH_ADEL_EN
          hold_adel_nx = 1'b0;
`endif
        end else begin
          valid = 1'b1;
          instr = hold_buf;
`ifdef IFETCH_ADEL_EN
          adel  = hold_adel;
`endif
          if (!stall_d) state_nx = S_REQ;
        end
      end
      S_DISCARD: begin
        // Squashed request still outstanding: swallow its data, issue nothing.
        if (inst_data_ok) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  // Every output reads zero while reset is held.
  assign inst_req    = ~reset & req;
  assign f_valid     = ~reset & valid;
  assign f_instr     = reset ? 32'h0 : instr;
  assign f_pc        = reset ? 32'h0 : pc;
  assign stall_f_req = ~reset & ~flush & (state != S_HOLD) & ~valid;
`ifdef IFETCH_ADEL_EN
  assign inst_addr   = reset ? 32'h0 : pc;
  assign f_adel      = ~reset & adel;
`else
  assign inst_addr   = reset ? 32'h0 : {pc[31:2], 2'b00};
  assign f_adel      = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        stall_d, flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        f_valid;
  logic [31:0] f_pc, f_instr;
  logic        f_adel, stall_f_req;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .stall_d(stall_d), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_adel(f_adel),
    .stall_f_req(stall_f_req)
  );

  // Advance to just after the next rising edge; inputs are then set and
  // outputs sampled a further #1 later, well away from either edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_d = 0; flush = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1; pc = 32'hBFC00000; idle_inputs();
    step(); step();
    #1;
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL reset_inst_req act=%b exp=0", inst_req); end
    n_cmp++; if (stall_f_req !== 1'b0) begin n_err++; $display("FAIL reset_stall_f_req act=%b exp=0", stall_f_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL reset_f_valid act=%b exp=0", f_valid); end
    n_cmp++; if (inst_addr !== 32'h0) begin n_err++; $display("FAIL reset_inst_addr act=%h exp=00000000", inst_addr); end
    step();
    reset = 0;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL post_reset_inst_req act=%b exp=1", inst_req); end
    n_cmp++; if (inst_addr !== 32'hBFC00000) begin n_err++; $display("FAIL post_reset_inst_addr act=%h exp=bfc00000", inst_addr); end
    step();
  endtask

  task automatic test_basic_fetch();
    pc = 32'hBFC00000; idle_inputs(); inst_addr_ok = 1;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL basic_c1_req act=%b exp=1", inst_req); end
    n_cmp++; if (stall_f_req !== 1'b1) begin n_err++; $display("FAIL basic_c1_stall act=%b exp=1", stall_f_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL basic_c1_valid act=%b exp=0", f_valid); end
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h24080001;
    #1;
    n_cmp++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL basic_c2_valid act=%b exp=1", f_valid); end
    n_cmp++; if (f_instr !== 32'h24080001) begin n_err++; $display("FAIL basic_c2_instr act=%h exp=24080001", f_instr); end
    n_cmp++; if (f_pc !== 32'hBFC00000) begin n_err++; $display("FAIL basic_c2_pc act=%h exp=bfc00000", f_pc); end
    n_cmp++; if (stall_f_req !== 1'b0) begin n_err++; $display("FAIL basic_c2_stall act=%b exp=0", stall_f_req); end
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL basic_c2_req act=%b exp=0", inst_req); end
    step();
    pc = 32'hBFC00004; idle_inputs();
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL basic_c3_req act=%b exp=1", inst_req); end
    n_cmp++; if (inst_addr !== 32'hBFC00004) begin n_err++; $display("FAIL basic_c3_addr act=%h exp=bfc00004", inst_addr); end
  endtask

  task automatic test_stall_hold();
    pc = 32'hBFC00004; idle_inputs(); inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h8C020004; stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] act=%b exp=1", i, f_valid); end
      n_cmp++; if (f_instr !== 32'h8C020004) begin n_err++; $display("FAIL hold_instr[%0d] act=%h exp=8c020004", i, f_instr); end
      n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] act=%b exp=0", i, inst_req); end
      step();
      inst_data_ok = 0; inst_rdata = 32'h0;
    end
    stall_d = 0;
    #1;
    n_cmp++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL hold_release_valid act=%b exp=1", f_valid); end
    n_cmp++; if (f_instr !== 32'h8C020004) begin n_err++; $display("FAIL hold_release_instr act=%h exp=8c020004", f_instr); end
    step();
    pc = 32'hBFC00008;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL hold_next_req act=%b exp=1", inst_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL hold_next_valid act=%b exp=0", f_valid); end
  endtask

  task automatic test_flush_discard();
    pc = 32'hBFC00008; idle_inputs(); inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; flush = 1;
    #1;
    n_cmp++; if (stall_f_req !== 1'b0) begin n_err++; $display("FAIL flush_stall act=%b exp=0", stall_f_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid act=%b exp=0", f_valid); end
    step();
    flush = 0; pc = 32'hBFC00380;
    #1;
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL discard_req act=%b exp=0", inst_req); end
    step();
    inst_data_ok = 1; inst_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL discard_drop_valid act=%b exp=0", f_valid); end
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL discard_drop_req act=%b exp=0", inst_req); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL redirect_req act=%b exp=1", inst_req); end
    n_cmp++; if (inst_addr !== 32'hBFC00380) begin n_err++; $display("FAIL redirect_addr act=%h exp=bfc00380", inst_addr); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL redirect_valid act=%b exp=0", f_valid); end
  endtask

  task automatic test_addr_ok_withheld();
    pc = 32'hBFC00380; idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL withheld_req[%0d] act=%b exp=1", i, inst_req); end
      n_cmp++; if (inst_addr !== 32'hBFC00380) begin n_err++; $display("FAIL withheld_addr[%0d] act=%h exp=bfc00380", i, inst_addr); end
      n_cmp++; if (stall_f_req !== 1'b1) begin n_err++; $display("FAIL withheld_stall[%0d] act=%b exp=1", i, stall_f_req); end
      step();
    end
    inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h00000000;
    step();
    idle_inputs();
  endtask

  task automatic test_flush_in_req_and_hold();
    pc = 32'hBFC00400; idle_inputs(); flush = 1; inst_addr_ok = 1;
    #1;
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL req_flush_req act=%b exp=0", inst_req); end
    step();
    flush = 0; inst_addr_ok = 0;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL req_after_flush_req act=%b exp=1", inst_req); end
    inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h11112222; stall_d = 1;
    step();
    inst_data_ok = 0; flush = 1;
    #1;
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL hold_flush_valid act=%b exp=0", f_valid); end
    n_cmp++; if (stall_f_req !== 1'b0) begin n_err++; $display("FAIL hold_flush_stall act=%b exp=0", stall_f_req); end
    step();
    idle_inputs(); pc = 32'hBFC00500;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL hold_flush_next_req act=%b exp=1", inst_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL hold_flush_next_valid act=%b exp=0", f_valid); end
  endtask

  task automatic test_adel();
    pc = 32'h80000002; idle_inputs();
    #1;
`ifdef IFETCH_ADEL_EN
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL adel_req act=%b exp=0", inst_req); end
    n_cmp++; if (f_valid !== 1'b1) begin n_err++; $display("FAIL adel_valid act=%b exp=1", f_valid); end
    n_cmp++; if (f_adel !== 1'b1) begin n_err++; $display("FAIL adel_flag act=%b exp=1", f_adel); end
    n_cmp++; if (f_instr !== 32'h0) begin n_err++; $display("FAIL adel_instr act=%h exp=00000000", f_instr); end
    step();
`else
    n_cmp++; if (inst_addr !== 32'h80000000) begin n_err++; $display("FAIL adel_addr act=%h exp=80000000", inst_addr); end
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL adel_req act=%b exp=1", inst_req); end
    n_cmp++; if (f_adel !== 1'b0) begin n_err++; $display("FAIL adel_flag act=%b exp=0", f_adel); end
    inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h3C1D8000;
    #1;
    n_cmp++; if (f_adel !== 1'b0) begin n_err++; $display("FAIL adel_data_flag act=%b exp=0", f_adel); end
    n_cmp++; if (f_instr !== 32'h3C1D8000) begin n_err++; $display("FAIL adel_data_instr act=%h exp=3c1d8000", f_instr); end
    step();
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    pc = 32'hBFC00600; idle_inputs(); inst_addr_ok = 1;
    step();
    inst_addr_ok = 0; reset = 1;
    #1;
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid act=%b exp=0", f_valid); end
    n_cmp++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL midreset_req act=%b exp=0", inst_req); end
    step();
    reset = 0; inst_data_ok = 1; inst_rdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL stale_valid act=%b exp=0", f_valid); end
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL stale_req act=%b exp=1", inst_req); end
    n_cmp++; if (stall_f_req !== 1'b1) begin n_err++; $display("FAIL stale_stall act=%b exp=1", stall_f_req); end
    step();
    inst_data_ok = 0;
    #1;
    n_cmp++; if (inst_req !== 1'b1) begin n_err++; $display("FAIL stale_after_req act=%b exp=1", inst_req); end
    n_cmp++; if (f_valid !== 1'b0) begin n_err++; $display("FAIL stale_after_valid act=%b exp=0", f_valid); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_flush_discard();
    test_addr_ok_withheld();
    test_flush_in_req_and_hold();
    test_adel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage control between the F pipeline register and the D pipeline register. Takes the current PC from the F register and runs one request/response transaction on the instruction SRAM-style bus. Produces the fetch-stage payload (pc, instr, valid, address-error flag) that the D register latches. Raises a stall request to the hazard unit while the instruction for the current PC is not yet available, and squashes in-flight fetches on redirect.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc  in  32  current fetch PC from the F register
- stall_d  in  1  D register not accepting this cycle (hazard.stallD)
- flush  in  1  redirect (branch or exception): squash the current fetch
- inst_req  out  1  bus request valid
- inst_addr  out  32  bus request address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- f_valid  out  1  payload valid for D register
- f_pc  out  32  PC of the payload
- f_instr  out  32  instruction word
- f_adel  out  1  instruction address error
- stall_f_req  out  1  hold PC: instruction for `pc` not yet delivered

## Operation
- FSM states: REQ, WAIT, HOLD, DISCARD. Reset enters REQ. hold_buf (32 b) holds the instruction in HOLD.
- REQ:
  - inst_req=1, inst_addr=pc.
  - inst_addr_ok → WAIT.
  - flush: inst_req forced 0 and state stays REQ.
- WAIT:
  - inst_data_ok & ~stall_d: f_valid=1 and f_instr=inst_rdata in the same cycle, then → REQ.
  - inst_data_ok & stall_d: capture inst_rdata into hold_buf, → HOLD. f_valid=1 in the capture cycle.
- HOLD:
  - f_valid=1, f_instr=hold_buf.
  - ~stall_d → REQ.
- DISCARD:
  - inst_req=0. f_valid=0.
  - inst_data_ok → REQ, data dropped.
- Flush priority: flush overrides stall_d and forces f_valid=0.
  - WAIT & flush: → DISCARD, or → REQ if inst_data_ok in the same cycle.
  - HOLD & flush: → REQ, hold_buf invalidated.
- f_pc is always equal to pc.
- stall_f_req is 1 whenever the state is not HOLD and no delivery happens this cycle. It is 0 in flush cycles (the hazard unit redirects the PC).
- inst_data_ok is ignored in REQ. The bus returns data no earlier than the cycle after addr_ok.
- Only one outstanding request. No request is issued while in DISCARD.

## Timing
- Reset values: state=REQ, hold_buf=0. All outputs are 0 during reset, including inst_req and stall_f_req.
- inst_req first rises in the cycle after reset deasserts.
- Best-case latency: addr_ok in cycle N, data_ok in cycle N+1, f_valid in cycle N+1 (combinational from inst_rdata).
- Throughput: one instruction per 2 cycles.
- The D register latches the payload at the edge ending the f_valid & ~stall_d cycle. The F register advances at that same edge.
- inst_req stays high with a stable inst_addr until inst_addr_ok, unless a flush occurs.
- Reset mid-transaction: return to REQ. A late inst_data_ok arriving in REQ is ignored.

## Configuration
- IFETCH_ADEL_EN defined:
  - pc[1:0] != 0 in REQ → no bus request.
  - f_valid=1, f_adel=1, f_instr=0 in that cycle (delivered like a normal fetch, including HOLD if stall_d is high).
- IFETCH_ADEL_EN undefined:
  - inst_addr = {pc[31:2],2'b00}.
  - f_adel tied to 0.

## Test plan
- pc=0xBFC00000, addr_ok immediate, data_ok next cycle with rdata=0x24080001 → f_valid=1 with f_instr=0x24080001 in cycle 2; stall_f_req=1 in cycle 1 only.
- data_ok with rdata=0x8C020004 while stall_d=1 for 3 cycles → f_valid held 3 cycles with f_instr=0x8C020004, no new inst_req until stall_d falls.
- flush in WAIT, data_ok 2 cycles later with rdata=0xDEADBEEF → f_valid stays 0 and the word is dropped; the next inst_req carries the new pc=0xBFC00380.
- addr_ok withheld 4 cycles → inst_req and inst_addr stable for all 4 cycles, stall_f_req=1 throughout.
- With IFETCH_ADEL_EN, pc=0x80000002 → inst_req=0, f_valid=1, f_adel=1, f_instr=0. Without it, inst_addr=0x80000000 and f_adel=0.
- Reset asserted in WAIT, then a stale data_ok → ignored; state REQ, f_valid=0.
